mbm_burst_ctrl: RTL and testbench

Burst access controller that acts as the initiator for the 2048×8 `Multi_Bank_Memory`. It accepts one read or write burst command at a time over a valid/ready handshake. It then streams write data in, or read data out, through valid/ready handshakes. It drives the memory's `ren`/`wen`/`waddr`/`raddr`/`din` port and captures `dout`. It sits between upstream datapath logic and the memory, so nothing upstream has to know the memory's one-cycle read latency.

---
 rtl/mbm_pkg.sv | 14 +
 rtl/mbm_rd_skid.sv | 49 ++++
 rtl/mbm_burst_ctrl.sv | 137 +++++++++++++
 tb/tb_mbm_burst_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mbm_pkg.sv
// Shared types and constants for the Multi_Bank_Memory burst controller.
package mbm_pkg;
    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 8;
    localparam int LEN_W        = 4;
    localparam int MBM_RD_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } mbm_state_t;
endpackage

// File: rtl/mbm_rd_skid.sv
// Two-entry read-data FIFO that absorbs memory read returns while the consumer stalls.
module mbm_rd_skid
    import mbm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);
    logic [DATA_W-1:0] r_buf [0:1];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_occ;
    logic              w_pop;
    logic              w_push;

    assign w_pop   = i_pop && (r_occ != 2'd0);
    assign w_push  = i_push && ((r_occ != 2'd2) || w_pop);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_buf[r_rd];
    assign o_occ   = r_occ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: rtl/mbm_burst_ctrl.sv
// Burst initiator for the 2048x8 Multi_Bank_Memory; hides the one-cycle read latency.
// Optional MBM_CTRL_WRAP_ERR_EN: reject bursts that would cross the top address, flag err.
module mbm_burst_ctrl
    import mbm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_rdata_valid,
    input  logic              i_rdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_raddr,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout
);
    mbm_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W:0]    r_cnt;
    logic              r_mem_ren;
    logic              r_ren_p1;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_raddr;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_din;
    logic [1:0]        w_occ;
    logic [2:0]        w_pending;
    logic              w_issue;
    logic              w_last;

    // Credits cover both the buffer and reads still travelling through the memory.
    assign w_pending = 3'(w_occ) + 3'(r_mem_ren) + 3'(r_ren_p1);
    assign w_issue   = (r_state == READ) && (w_pending < 3'(MBM_RD_DEPTH));
    assign w_last    = (r_cnt == (LEN_W+1)'(1));

`ifdef MBM_CTRL_WRAP_ERR_EN
    logic              r_err;
    logic [ADDR_W:0]   w_end;
    assign w_end = {1'b0, i_cmd_addr} + (ADDR_W+1)'(i_cmd_len);
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_mem_ren   <= 1'b0;
            r_ren_p1    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_waddr <= '0;
            r_mem_din   <= '0;
`ifdef MBM_CTRL_WRAP_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_mem_wen <= 1'b0;
            r_mem_ren <= w_issue;
            r_ren_p1  <= r_mem_ren;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr <= i_cmd_addr;
                        r_cnt  <= (LEN_W+1)'(i_cmd_len) + (LEN_W+1)'(1);
`ifdef MBM_CTRL_WRAP_ERR_EN
                        if (w_end[ADDR_W]) begin
                            r_err   <= 1'b1;
                            r_state <= DRAIN;
                        end else begin
                            r_state <= i_cmd_write ? WRITE : READ;
                        end
`else
                        r_state <= i_cmd_write ? WRITE : READ;
`endif
                    end
                end
                WRITE: begin
                    if (i_wdata_valid) begin
                        r_mem_wen   <= 1'b1;
                        r_mem_waddr <= r_addr;
                        r_mem_din   <= i_wdata;
                        r_addr      <= r_addr + 1'b1;
                        r_cnt       <= r_cnt - 1'b1;
                        if (w_last) r_state <= IDLE;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_mem_raddr <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        r_cnt       <= r_cnt - 1'b1;
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((w_occ == 2'd0) && !r_mem_ren && !r_ren_p1) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory returns data the cycle after it samples ren; capture it one cycle later.
    mbm_rd_skid u_rd_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_ren_p1),
        .i_data  (i_mem_dout),
        .i_pop   (i_rdata_ready),
        .o_valid (o_rdata_valid),
        .o_data  (o_rdata),
        .o_occ   (w_occ)
    );

    assign o_cmd_ready   = (r_state == IDLE);
    assign o_wdata_ready = (r_state == WRITE);
    assign o_busy        = (r_state != IDLE);
    assign o_mem_ren     = r_mem_ren;
    assign o_mem_wen     = r_mem_wen;
    assign o_mem_raddr   = r_mem_raddr;
    assign o_mem_waddr   = r_mem_waddr;
    assign o_mem_din     = r_mem_din;
endmodule

// File: tb/tb_mbm_burst_ctrl.sv
// Directed, table-driven bench for mbm_burst_ctrl with a behavioural 2048x8 memory.
module tb_mbm_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [10:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [7:0]  wdata = '0;
    logic        rdata_valid, rdata_ready = 1'b0;
    logic [7:0]  rdata;
    logic        busy, err, mem_ren, mem_wen;
    logic [10:0] mem_raddr, mem_waddr;
    logic [7:0]  mem_din, mem_dout = '0;
    logic [7:0]  mem [0:2047];

    int n_checks = 0, n_pass = 0;
    int n_ovl = 0, n_cred = 0, outst = 0, n_acc = 0, last_raddr = -1;
    int wq_a[$], wq_d[$];

    always #5 clk = ~clk;

    mbm_burst_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
        .o_busy(busy), .o_err(err),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .o_mem_raddr(mem_raddr), .o_mem_waddr(mem_waddr),
        .o_mem_din(mem_din), .i_mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_raddr];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            outst = 0;
        end else begin
            if (mem_ren && mem_wen) n_ovl++;
            if (mem_wen) begin
                wq_a.push_back(int'(mem_waddr));
                wq_d.push_back(int'(mem_din));
            end
            if (mem_ren) begin
                outst++;
                last_raddr = int'(mem_raddr);
            end
            if (rdata_valid && rdata_ready) outst--;
            if (outst > 2) n_cred++;
            if (cmd_valid && cmd_ready) n_acc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check({tag, "_wdata_ready"}, int'(wdata_ready), 0);
        check({tag, "_rdata_valid"}, int'(rdata_valid), 0);
        check({tag, "_rdata"}, int'(rdata), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_mem_ren"}, int'(mem_ren), 0);
        check({tag, "_mem_wen"}, int'(mem_wen), 0);
        check({tag, "_mem_raddr"}, int'(mem_raddr), 0);
        check({tag, "_mem_waddr"}, int'(mem_waddr), 0);
        check({tag, "_mem_din"}, int'(mem_din), 0);
    endtask

    task automatic do_cmd(input bit wr, input int addr, input int len);
        int g;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 11'(addr); cmd_len = 4'(len);
        g = 0;
        do begin @(negedge clk); g++; end while (!cmd_ready && g < 50);
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int len, input int d0, input int period, input int exp_last);
        int got, cyc, g;
        got = 0; cyc = 0;
        while (got <= len && cyc < 400) begin
            @(posedge clk); #1;
            rdata_ready = (period == 0) ? 1'b1 : (((cyc / period) % 2) == 0);
            @(negedge clk);
            if (rdata_valid && rdata_ready) begin
                check("rd_data", int'(rdata), (d0 + got) % 256);
                got++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        if (got <= len) check("rd_beat_timeout", got, len + 1);
        g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 20);
        check("rd_busy_low", int'(busy), 0);
        check("rd_no_extra_data", int'(rdata_valid), 0);
        check("rd_last_raddr", last_raddr, exp_last);
    endtask

    task automatic do_write(input int addr, input int len, input int d0, input int exp_last);
        int i, g;
        bit ok;
        wq_a.delete(); wq_d.delete();
        do_cmd(1'b1, addr, len);
        i = 0; g = 0;
        while (i <= len && g < 100) begin
            wdata_valid = 1'b1; wdata = 8'(d0 + i);
            @(negedge clk); ok = wdata_ready;
            @(posedge clk); #1;
            if (ok) i++;
            g++;
        end
        wdata_valid = 1'b0;
        if (i <= len) check("wr_beat_timeout", i, len + 1);
        check("wr_full_rate", g, len + 1);
        @(negedge clk);
        check("wr_last_wen", int'(mem_wen), 1);
        check("wr_last_waddr", int'(mem_waddr), exp_last);
        check("wr_busy_fall", int'(busy), 0);
        @(posedge clk); #1;
        check("wr_pulse_count", wq_a.size(), len + 1);
        for (int k = 0; k < wq_a.size() && k <= len; k++) begin
            check("wr_addr", wq_a[k], (addr + k) % 2048);
            check("wr_data", wq_d[k], (d0 + k) % 256);
        end
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        int d0;
        int period;
        int exp_last;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int cnt, got, acc0;

        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;

        vecs[0] = '{1'b1,   60, 0,  66, 0,   60};
        vecs[1] = '{1'b0,   60, 0,  66, 0,   60};
        vecs[2] = '{1'b1,  100, 3, 120, 0,  103};
        vecs[3] = '{1'b0,  100, 3, 120, 0,  103};
        vecs[4] = '{1'b1,  300, 7,  30, 0,  307};
        vecs[5] = '{1'b0,  300, 7,  30, 3,  307};
        vecs[6] = '{1'b1, 2046, 2, 200, 0,    0};
        vecs[7] = '{1'b0, 2046, 2, 200, 0,    0};
        vecs[8] = '{1'b0,    0, 0, 202, 0,    0};

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].exp_last);
            else begin
                do_cmd(1'b0, vecs[v].addr, vecs[v].len);
                collect(vecs[v].len, vecs[v].d0, vecs[v].period, vecs[v].exp_last);
            end
        end

        // First-data latency and single-cycle rdata_valid.
        do_cmd(1'b0, 60, 0);
        rdata_ready = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!rdata_valid && cnt < 10);
        check("lat_first_data", cnt, 4);
        check("lat_rdata", int'(rdata), 66);
        @(negedge clk);
        check("lat_valid_one_cycle", int'(rdata_valid), 0);
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (busy && cnt < 20);
        check("lat_busy_low", int'(busy), 0);

        // Command held while busy must be accepted exactly once after the write.
        acc0 = n_acc;
        do_cmd(1'b1, 500, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'd500; cmd_len = 4'd1;
        for (int b = 0; b < 2; b++) begin
            wdata_valid = 1'b1; wdata = 8'(77 + b);
            @(negedge clk);
            check("hold_cmd_ready", int'(cmd_ready), 0);
            check("hold_wdata_ready", int'(wdata_ready), 1);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        check("hold_cmd_ready_idle", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_busy_after_accept", int'(busy), 1);
        collect(1, 77, 0, 501);
        check("hold_accept_once", n_acc - acc0, 2);

        // Asynchronous reset during beat 3 of an 8-beat read.
        do_cmd(1'b0, 300, 7);
        rdata_ready = 1'b1;
        got = 0; cnt = 0;
        while (got < 2 && cnt < 50) begin
            @(negedge clk);
            if (rdata_valid) begin
                check("mid_rd_data", int'(rdata), 30 + got);
                got++;
            end
            cnt++;
        end
        check("mid_beats_before_reset", got, 2);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid");
        rdata_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(1'b0, 60, 0);
        collect(0, 66, 0, 60);

        check("no_ren_wen_overlap", n_ovl, 0);
        check("credit_limit", n_cred, 0);
        check("err_default", int'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
